// File: rtl/twocomp_to_sm_serial.sv
// Serial two's-complement to sign/magnitude converter: accepts one 8-bit word,
// processes it LSB first over 8 cycles, then holds the result until taken.
module twocomp_to_sm_serial (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sign,
    output logic [7:0] mag,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] mag_q,   mag_d;
    logic [2:0] cnt_q,   cnt_d;
    logic       seen_q,  seen_d;
    logic       sign_q,  sign_d;
    logic       res_bit;

    // Negative words: copy bits up to and including the first 1, invert above it.
    assign res_bit = shreg_q[0] ^ (sign_q & seen_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        shreg_d   = shreg_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        sign_d    = sign_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d = a;
                    sign_d  = a[7];
                    cnt_d   = 3'd0;
                    seen_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                shreg_d = {1'b0, shreg_q[7:1]};
                mag_d   = {res_bit, mag_q[7:1]};
                seen_d  = seen_q | shreg_q[0];
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= 8'h00;
            mag_q   <= 8'h00;
            cnt_q   <= 3'd0;
            seen_q  <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            sign_q  <= sign_d;
        end
    end

    assign sign = sign_q;
    assign mag  = mag_q;

endmodule

// File: tb/tb_twocomp_to_sm_serial.sv
// Directed and randomised checks of the serial two's-complement to
// sign/magnitude converter, including stalls, held inputs and aborts.
module tb_twocomp_to_sm_serial;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic       out_valid;
    logic       out_ready;
    logic       sign;
    logic [7:0] mag;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    twocomp_to_sm_serial dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .mag       (mag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [7:0] val, input int stall, input bit hold,
                            input logic exp_sign, input logic [7:0] exp_mag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);

        in_valid = 1'b1;
        a        = val;
        step();
        if (!hold) in_valid = 1'b0;
        a = 8'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("in_ready_in_shift", {31'd0, in_ready}, 32'd0);

        n = 0;
        while (!out_valid && n < 20) begin
            out_ready = 1'($urandom);
            if (hold) a = 8'($urandom);
            step();
            n++;
        end
        check("latency", 32'(n), 32'd8);
        check("sign", {31'd0, sign}, {31'd0, exp_sign});
        check("mag", {24'd0, mag}, {24'd0, exp_mag});

        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            if (hold) a = 8'($urandom);
            step();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_sign", {31'd0, sign}, {31'd0, exp_sign});
            check("stall_mag", {24'd0, mag}, {24'd0, exp_mag});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_xfer_valid", {31'd0, out_valid}, 32'd0);
        check("post_xfer_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_xfer_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         ov_count;
        logic [7:0] rv;
        logic [7:0] rmag;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sign", {31'd0, sign}, 32'd0);
        check("rst_mag", {24'd0, mag}, 32'd0);

        // Reset wins over a simultaneous handshake.
        in_valid = 1'b1;
        a        = 8'hAA;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("prio_in_ready", {31'd0, in_ready}, 32'd1);
        check("prio_busy", {31'd0, busy}, 32'd0);
        check("prio_sign", {31'd0, sign}, 32'd0);

        run_word(8'hFB, 0, 1'b0, 1'b1, 8'h05);
        run_word(8'h80, 0, 1'b0, 1'b1, 8'h80);
        run_word(8'h00, 0, 1'b0, 1'b0, 8'h00);
        run_word(8'h7F, 0, 1'b0, 1'b0, 8'h7F);
        run_word(8'hFF, 5, 1'b0, 1'b1, 8'h01);
        run_word(8'h3C, 3, 1'b1, 1'b0, 8'h3C);
        run_word(8'h9A, 1, 1'b1, 1'b1, 8'h66);

        // Abort a word in flight at SHIFT count 4.
        in_valid = 1'b1;
        a        = 8'hC0;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_mag", {24'd0, mag}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        ov_count = 0;
        for (int i = 0; i < 12; i++) begin
            out_ready = 1'($urandom);
            step();
            if (out_valid) ov_count++;
        end
        out_ready = 1'b0;
        check("abort_no_stale", 32'(ov_count), 32'd0);

        for (int k = 0; k < 256; k++) begin
            rv   = 8'($urandom);
            rmag = rv[7] ? 8'(-rv) : rv;
            run_word(rv, int'($urandom_range(0, 3)), 1'($urandom), rv[7], rmag);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
